// File: rtl/xgmii_to_fifo72_pkg.sv
// xgmii_to_fifo72_pkg -- XGMII control codes, reference words and receive FSM states.
// Rev 1.0
`default_nettype none

package xgmii_to_fifo72_pkg;

   localparam logic [7:0]  XGMII_IDLE  = 8'h07;
   localparam logic [7:0]  XGMII_START = 8'hFB;
   localparam logic [7:0]  XGMII_TERM  = 8'hFD;
   localparam logic [7:0]  XGMII_ERROR = 8'hFE;
   localparam logic [7:0]  XGMII_SEQ   = 8'h9C;

   localparam logic [71:0] XGMII_IDLE_WORD  = 72'hff_07_07_07_07_07_07_07_07;
   localparam logic [71:0] XGMII_ABORT_WORD = 72'hff_07_07_07_07_07_07_07_FE;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FRAME = 2'd1,
      ST_DROP  = 2'd2,
      ST_ABORT = 2'd3
   } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/xgmii_rx_lane_decode.sv
// xgmii_rx_lane_decode -- stateless lane-0 start and any-lane terminate detection.
// Rev 1.0
`default_nettype none

module xgmii_rx_lane_decode
   import xgmii_to_fifo72_pkg::*;
(
   input  logic [71:0] word_i,
   output logic        is_start_o,
   output logic        has_term_o
);

   assign is_start_o = word_i[64] && (word_i[7:0] == XGMII_START);

   always_comb begin
      has_term_o = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (word_i[64+i] && (word_i[8*i +: 8] == XGMII_TERM)) begin
            has_term_o = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/xgmii_to_fifo72.sv
// xgmii_to_fifo72 -- XGMII receive words to a 72-bit FIFO, aborting frames cut by FIFO full.
// Rev 1.0 -- optional statistics counters built with XGMII_RX_STATS_EN.
`default_nettype none

module xgmii_to_fifo72
   import xgmii_to_fifo72_pkg::*;
(
   input  logic        xgmii_rx_clk,
   input  logic        sys_rst_n,
   input  logic [71:0] xgmii_rxd,
   output logic [71:0] din,
   output logic        wr_en,
   input  logic        full,
   output logic        wr_clk
`ifdef XGMII_RX_STATS_EN
   ,
   output logic [31:0] rx_frames,
   output logic [31:0] rx_drops
`endif
);

   logic        is_start;
   logic        has_term;
   rx_state_t   state_q, state_d;
   logic [71:0] din_q, din_d;
   logic        wr_en_q, wr_en_d;
   logic        term_seen_q, term_seen_d;

   assign wr_clk = xgmii_rx_clk;
   assign din    = din_q;
   assign wr_en  = wr_en_q;

   xgmii_rx_lane_decode u_decode (
      .word_i     (xgmii_rxd),
      .is_start_o (is_start),
      .has_term_o (has_term)
   );

   always_comb begin
      state_d     = state_q;
      din_d       = din_q;
      wr_en_d     = 1'b0;
      term_seen_d = term_seen_q;
      unique case (state_q)
         ST_IDLE: begin
            if (is_start) begin
               if (!full) begin
                  wr_en_d = 1'b1;
                  din_d   = xgmii_rxd;
               end
               if (!has_term) begin
                  state_d = full ? ST_DROP : ST_FRAME;
               end
            end
         end
         ST_FRAME: begin
            if (!full) begin
               wr_en_d = 1'b1;
               din_d   = xgmii_rxd;
               if (has_term) state_d = ST_IDLE;
            end else begin
               term_seen_d = has_term;
               state_d     = ST_ABORT;
            end
         end
         ST_ABORT: begin
            // The terminate may arrive while still blocked; it decides where the abort lands.
            term_seen_d = term_seen_q | has_term;
            if (!full) begin
               wr_en_d     = 1'b1;
               din_d       = XGMII_ABORT_WORD;
               term_seen_d = 1'b0;
               state_d     = (term_seen_q | has_term) ? ST_IDLE : ST_DROP;
            end
         end
         ST_DROP: begin
            if (has_term) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge xgmii_rx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_IDLE;
         din_q       <= XGMII_IDLE_WORD;
         wr_en_q     <= 1'b0;
         term_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         din_q       <= din_d;
         wr_en_q     <= wr_en_d;
         term_seen_q <= term_seen_d;
      end
   end

`ifdef XGMII_RX_STATS_EN
   logic        count_frame;
   logic        count_drop;
   logic        frame_word;
   logic [31:0] frames_q, frames_d;
   logic [31:0] drops_q, drops_d;

   assign frame_word  = ((state_q == ST_IDLE) && is_start) || (state_q == ST_FRAME);
   assign count_frame = frame_word && !full && has_term;
   assign count_drop  = frame_word && full;
   assign frames_d    = frames_q + {31'd0, count_frame};
   assign drops_d     = drops_q + {31'd0, count_drop};
   assign rx_frames   = frames_q;
   assign rx_drops    = drops_q;

   always_ff @(posedge xgmii_rx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         frames_q <= 32'd0;
         drops_q  <= 32'd0;
      end else begin
         frames_q <= frames_d;
         drops_q  <= drops_d;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_xgmii_to_fifo72.sv
// tb_xgmii_to_fifo72 -- directed scenarios plus random traffic against a frame-level reference model.
// Rev 1.0 -- counter checks built with XGMII_RX_STATS_EN.
`default_nettype none

module tb_xgmii_to_fifo72;

   localparam logic [71:0] IDLE_W  = 72'hff_07_07_07_07_07_07_07_07;
   localparam logic [71:0] ABORT_W = 72'hff_07_07_07_07_07_07_07_FE;

   logic        xgmii_rx_clk = 1'b0;
   logic        sys_rst_n;
   logic [71:0] xgmii_rxd;
   logic [71:0] din;
   logic        wr_en;
   logic        full;
   logic        wr_clk;
`ifdef XGMII_RX_STATS_EN
   logic [31:0] rx_frames;
   logic [31:0] rx_drops;
`endif

   always #5 xgmii_rx_clk = ~xgmii_rx_clk;

   xgmii_to_fifo72 dut (
      .xgmii_rx_clk (xgmii_rx_clk),
      .sys_rst_n    (sys_rst_n),
      .xgmii_rxd    (xgmii_rxd),
      .din          (din),
      .wr_en        (wr_en),
      .full         (full),
      .wr_clk       (wr_clk)
`ifdef XGMII_RX_STATS_EN
      ,
      .rx_frames    (rx_frames),
      .rx_drops     (rx_drops)
`endif
   );

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [71:0] obs_q[$];
   logic [71:0] frm[16];

   // Reference model: tracks frame progress in the input stream, not RTL states.
   bit          m_in_frame, m_dropping, m_abort_pending, m_term_seen;
   logic [31:0] m_frames, m_drops;
   logic        exp_wr;
   logic [71:0] exp_din;

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fails++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, expv, $time);
      end
   endtask

   function automatic bit w_start(input logic [71:0] w);
      return w[64] && (w[7:0] == 8'hFB);
   endfunction

   function automatic bit w_term(input logic [71:0] w);
      bit t = 0;
      for (int i = 0; i < 8; i++)
         if (w[64+i] && (w[8*i +: 8] == 8'hFD)) t = 1;
      return t;
   endfunction

   task automatic model_reset();
      m_in_frame = 0; m_dropping = 0; m_abort_pending = 0; m_term_seen = 0;
      m_frames = 32'd0; m_drops = 32'd0;
   endtask

   task automatic model_step(input logic [71:0] w, input logic f);
      bit s, t;
      s = w_start(w);
      t = w_term(w);
      exp_wr  = 1'b0;
      exp_din = w;
      if (m_abort_pending) begin
         m_term_seen = m_term_seen | t;
         if (!f) begin
            exp_wr = 1'b1; exp_din = ABORT_W;
            m_abort_pending = 0;
            m_in_frame = !m_term_seen;
            m_dropping = m_in_frame;
         end
      end else if (!m_in_frame) begin
         if (s) begin
            if (f) m_drops++;
            else begin
               exp_wr = 1'b1;
               if (t) m_frames++;
            end
            m_in_frame = !t;
            m_dropping = f;
         end
      end else if (m_dropping) begin
         if (t) m_in_frame = 0;
      end else if (f) begin
         m_drops++;
         m_abort_pending = 1;
         m_term_seen = t;
      end else begin
         exp_wr = 1'b1;
         if (t) begin
            m_frames++;
            m_in_frame = 0;
         end
      end
   endtask

   task automatic cycle(input logic [71:0] w, input logic f);
      xgmii_rxd = w;
      full      = f;
      model_step(w, f);
      @(posedge xgmii_rx_clk);
      @(negedge xgmii_rx_clk);
      check("wr_en", {71'd0, wr_en}, {71'd0, exp_wr});
      if (exp_wr) check("din", din, exp_din);
      if (wr_en) obs_q.push_back(din);
`ifdef XGMII_RX_STATS_EN
      check("rx_frames", {40'd0, rx_frames}, {40'd0, m_frames});
      check("rx_drops", {40'd0, rx_drops}, {40'd0, m_drops});
`endif
   endtask

   function automatic logic [71:0] mk_data();
      return {8'h00, $urandom(), $urandom()};
   endfunction

   function automatic logic [71:0] mk_start();
      logic [71:0] w;
      w = mk_data();
      w[64] = 1'b1;
      w[7:0] = 8'hFB;
      return w;
   endfunction

   function automatic logic [71:0] mk_term(input int lane);
      logic [71:0] w;
      w = mk_data();
      for (int i = 0; i < 8; i++) begin
         if (i == lane) begin
            w[64+i] = 1'b1; w[8*i +: 8] = 8'hFD;
         end else if (i > lane) begin
            w[64+i] = 1'b1; w[8*i +: 8] = 8'h07;
         end
      end
      return w;
   endfunction

   task automatic build_frame(input int n, input int lane);
      frm[0] = mk_start();
      for (int i = 1; i < n - 1; i++) frm[i] = mk_data();
      frm[n-1] = mk_term(lane);
   endtask

   task automatic check_counts(input string tag, input logic [31:0] fr, input logic [31:0] dr);
`ifdef XGMII_RX_STATS_EN
      check({tag, "_frames"}, {40'd0, rx_frames}, {40'd0, fr});
      check({tag, "_drops"}, {40'd0, rx_drops}, {40'd0, dr});
`else
      if (fr != m_frames || dr != m_drops) check({tag, "_model"}, 72'd0, 72'd1);
`endif
   endtask

   initial begin
      logic [71:0] w;
      sys_rst_n = 1'b0;
      xgmii_rxd = IDLE_W;
      full      = 1'b0;
      model_reset();
      repeat (3) @(negedge xgmii_rx_clk);
      check("rst_wr_en", {71'd0, wr_en}, 72'd0);
      check("rst_din", din, IDLE_W);
      check("wr_clk_follows", {71'd0, wr_clk}, {71'd0, xgmii_rx_clk});
      sys_rst_n = 1'b1;

      // Idles after reset
      obs_q.delete();
      repeat (3) cycle(IDLE_W, 1'b0);
      check("idle_writes", obs_q.size(), 0);
      check("idle_din", din, IDLE_W);
      check_counts("idle", 32'd0, 32'd0);

      // Clean frame, terminate in lane 3
      obs_q.delete();
      build_frame(8, 3);
      for (int i = 0; i < 8; i++) cycle(frm[i], 1'b0);
      check("good_writes", obs_q.size(), 8);
      for (int i = 0; i < 8; i++) check("good_word", obs_q[i], frm[i]);
      check_counts("good", 32'd1, 32'd0);

      // Full on word 3 for two cycles, released before terminate
      obs_q.delete();
      build_frame(8, 5);
      for (int i = 0; i < 8; i++) cycle(frm[i], (i == 3 || i == 4));
      check("cut_writes", obs_q.size(), 4);
      for (int i = 0; i < 3; i++) check("cut_word", obs_q[i], frm[i]);
      check("cut_abort", obs_q[3], ABORT_W);
      check_counts("cut", 32'd1, 32'd1);

      // Full at start, released mid-frame; next frame intact
      obs_q.delete();
      build_frame(8, 2);
      for (int i = 0; i < 8; i++) cycle(frm[i], (i < 4));
      check("blocked_writes", obs_q.size(), 0);
      build_frame(6, 0);
      for (int i = 0; i < 6; i++) cycle(frm[i], 1'b0);
      check("after_block_writes", obs_q.size(), 6);
      check("after_block_last", obs_q[5], frm[5]);
      check_counts("blocked", 32'd2, 32'd2);

      // Full held through terminate, released 4 cycles later
      obs_q.delete();
      build_frame(8, 7);
      for (int i = 0; i < 8; i++) cycle(frm[i], (i >= 3));
      repeat (3) cycle(IDLE_W, 1'b1);
      cycle(IDLE_W, 1'b0);
      check("held_writes", obs_q.size(), 4);
      check("held_abort", obs_q[3], ABORT_W);
      obs_q.delete();
      build_frame(3, 4);
      for (int i = 0; i < 3; i++) cycle(frm[i], 1'b0);
      check("held_next_writes", obs_q.size(), 3);
      check("held_next_start", obs_q[0], frm[0]);
      check_counts("held", 32'd3, 32'd3);

`ifdef XGMII_RX_STATS_EN
      // Frame counter wrap
      force dut.frames_q = 32'hFFFF_FFFF;
      #1 release dut.frames_q;
      m_frames = 32'hFFFF_FFFF;
      check("preload_frames", {40'd0, rx_frames}, {40'd0, m_frames});
      build_frame(4, 1);
      for (int i = 0; i < 4; i++) cycle(frm[i], 1'b0);
      check("wrap_frames", {40'd0, rx_frames}, 72'd0);
`endif

      // Reset mid-frame: immediate wr_en drop, no abort, no count
      build_frame(6, 6);
      cycle(frm[0], 1'b0);
      cycle(frm[1], 1'b0);
      sys_rst_n = 1'b0;
      #1;
      check("midrst_wr_en", {71'd0, wr_en}, 72'd0);
      check("midrst_din", din, IDLE_W);
      model_reset();
      @(negedge xgmii_rx_clk);
      sys_rst_n = 1'b1;
      obs_q.delete();
      for (int i = 2; i < 6; i++) cycle(frm[i], 1'b0);
      check("midrst_writes", obs_q.size(), 0);
      check_counts("midrst", 32'd0, 32'd0);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 7))
            0: w = IDLE_W;
            1: w = mk_start();
            2, 3: w = mk_data();
            4: w = mk_term($urandom_range(0, 7));
            5: begin
               w = mk_term($urandom_range(1, 7));
               w[64] = 1'b1;
               w[7:0] = 8'hFB;
            end
            6: begin
               w = mk_data();
               w[64] = 1'b1;
               w[7:0] = 8'h9C;
            end
            default: begin
               w = mk_data();
               w[71:64] = 8'h1F;
               w[39:0] = 40'hFB_07_07_07_07;
            end
         endcase
         cycle(w, ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/xgmii_to_fifo72.md
XGMII_TO_FIFO72 -- requirements
Module: xgmii_to_fifo72

Interface
REQ-001 SHALL have port xgmii_rx_clk, input, 1: sole clock; also drives wr_clk.
REQ-002 SHALL have port sys_rst_n, input, 1: asynchronous reset, active-low.
REQ-003 SHALL have port xgmii_rxd, input, 72: [71:64] per-lane control flags (bit 64 = lane 0), [63:0] data (lane 0 = [7:0]).
REQ-004 SHALL have port din, output, 72: FIFO write word, same format as xgmii_rxd.
REQ-005 SHALL have port wr_en, output, 1: FIFO write strobe.
REQ-006 SHALL have port full, input, 1: FIFO full flag.
REQ-007 SHALL have port wr_clk, output, 1: continuous assign from xgmii_rx_clk.
REQ-008 SHALL have ports rx_frames and rx_drops, each output, 32: statistics counters; present only per REQ-025.

Function
REQ-009 SHALL use the following lane terms: start = lane 0 ctrl=1 and data 0xFB; terminate = any lane with ctrl=1 and data 0xFD; abort word = 72'hff_07_07_07_07_07_07_07_FE.
REQ-010 SHALL implement a four-state FSM: IDLE, FRAME, DROP, ABORT.
REQ-011 SHALL register all outputs, with din/wr_en valid one cycle after the input word is sampled.
REQ-012 IDLE: SHALL write nothing for non-start words, including idles, 0x9C ordered sets and lane-4 starts.
REQ-013 IDLE, start, full=0: SHALL write the word; if it also contains terminate, stay IDLE and count a frame, else go to FRAME.
REQ-014 IDLE, start, full=1: SHALL write nothing and count a drop; if the word contains terminate, stay IDLE, else go to DROP.
REQ-015 FRAME, full=0: SHALL write every word unmodified, including 0xFE and stray 0xFB; on terminate, write it, count a frame and go to IDLE.
REQ-016 FRAME, full=1: SHALL write nothing, count a drop, latch term_seen = (word contains terminate) and go to ABORT.
REQ-017 ABORT: SHALL OR terminate detection into term_seen each cycle; on the first cycle with full=0, write the abort word, then go to IDLE if term_seen else to DROP.
REQ-018 ABORT: SHALL ignore start words while in this state.
REQ-019 DROP: SHALL write nothing and go to IDLE on the cycle after a terminate.
REQ-020 SHALL assert wr_en only when full was 0 in the same sampled cycle, so the FIFO is never written while full.
REQ-021 SHALL wrap counters modulo 2^32 without saturating; each counter increments at most once per cycle.

Reset
REQ-022 On sys_rst_n low, asynchronously: state=IDLE, wr_en=0, din=72'hff_07_07_07_07_07_07_07_07, term_seen=0, counters=0.
REQ-023 Reset asserted mid-frame SHALL discard the frame with no abort word and no count; the first word after deassertion is evaluated in IDLE.
REQ-024 Reset deassertion SHALL be synchronised externally; the block contains no synchroniser.

Configuration
REQ-025 With XGMII_RX_STATS_EN defined, SHALL build the rx_frames/rx_drops ports and counters per REQ-013..REQ-016 and REQ-021.
REQ-026 Without XGMII_RX_STATS_EN, SHALL omit the ports and counters, leaving the datapath bit-identical in behaviour.

Structure
REQ-027 Shared package SHALL hold the XGMII constants (IDLE 0x07, START 0xFB, TERM 0xFD, ERROR 0xFE, SEQ 0x9C), the idle and abort 72-bit words, and the FSM state enum.
REQ-028 SHALL use one sub-module, xgmii_rx_lane_decode: combinational, producing is_start and has_term from a 72-bit word, with no state.
REQ-029 The top level SHALL hold the FSM, output registers and counters.

Verification
REQ-030 Bench SHALL check: reset, then 3 idle words -> wr_en=0, din=ff_07x8, counters 0.
REQ-031 Bench SHALL check: full=0, start + 6 data words + terminate in lane 3 -> 8 writes, each 1 cycle after input and bit-exact; rx_frames=1.
REQ-032 Bench SHALL check: full asserted on data word 3 of 8, deasserted 2 cycles later before terminate -> 3 words written, then abort word, then no writes until terminate; rx_drops=1, rx_frames=0.
REQ-033 Bench SHALL check: full=1 at start word, released mid-frame -> zero writes for that frame; next frame written fully; rx_drops=1, rx_frames=1.
REQ-034 Bench SHALL check: full held through terminate, released 4 cycles later -> single abort word, FSM back in IDLE, following start accepted.
REQ-035 Bench SHALL check: preload rx_frames=0xFFFFFFFF by forcing, then one good frame -> rx_frames=0; sys_rst_n pulsed mid-frame -> wr_en=0 in same cycle, no abort word.
